// File: rtl/atpg_pkg.sv
// Shared types and constants for the ATPG pattern sequencer.
// The optional MISR signature is built only when ATPG_MISR_EN is defined.
package atpg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } atpg_state_t;

    localparam logic [15:0] ATPG_MISR_POLY = 16'h1021;
    localparam logic [15:0] ATPG_MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/atpg_misr.sv
// Galois MISR that compacts the single-bit CUT response stream.
// init reloads the seed; shift folds din into the signature.
module atpg_misr
    import atpg_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(ATPG_MISR_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(ATPG_MISR_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             shift,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic             w_fb;

    assign w_fb = r_sig[SIG_W-1] ^ din;
    assign sig  = r_sig;

    // Signature register: seed on init, fold one response bit per shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (init) begin
            r_sig <= SEED;
        end else if (shift) begin
            r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/atpg_pattern_sequencer.sv
// Applies incrementing test patterns to a 5-input CUT, waits SETTLE_CYC
// cycles, captures the response and compares it against the golden bit.
// Optional feature: define ATPG_MISR_EN to add the signature_o MISR.
module atpg_pattern_sequencer
    import atpg_pkg::*;
#(
    parameter int unsigned NUM_IN     = 5,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned SIG_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [NUM_IN-1:0] seed_i,
    input  logic [CNT_W-1:0]  num_pat_i,
    output logic [NUM_IN-1:0] pat_o,
    input  logic              resp_i,
    input  logic              exp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic              first_fail_vld_o,
    output logic [CNT_W-1:0]  first_fail_idx_o
`ifdef ATPG_MISR_EN
    ,
    output logic [SIG_W-1:0]  signature_o
`endif
);

    // Elaboration-time guard on the configuration.
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || SIG_W < 2) begin : g_param_check
        $error("atpg_pattern_sequencer: SETTLE_CYC must be 1..15 and SIG_W >= 2");
    end

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    atpg_state_t       r_state;
    atpg_state_t       w_state_nxt;
    logic [NUM_IN-1:0] r_pat;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_num;
    logic [3:0]        r_settle;
    logic [CNT_W-1:0]  r_fail;
    logic              r_ff_vld;
    logic [CNT_W-1:0]  r_ff_idx;
    logic              r_aborted;

    logic w_start_any;
    logic w_start_run;
    logic w_active;
    logic w_abort;
    logic w_capture;
    logic w_last;
    logic w_settle_end;
    logic w_mismatch;

    assign w_active     = (r_state == ST_APPLY) || (r_state == ST_SETTLE) ||
                          (r_state == ST_CAPTURE);
    assign w_abort      = w_active && abort_i;
    assign w_start_any  = (r_state == ST_IDLE) && start_i;
    assign w_start_run  = w_start_any && (num_pat_i != '0);
    assign w_capture    = (r_state == ST_CAPTURE) && !abort_i;
    assign w_last       = (r_idx == r_num - 1'b1);
    assign w_settle_end = (r_settle == SETTLE_LAST);
    assign w_mismatch   = resp_i ^ exp_i;

    assign pat_o            = r_pat;
    assign aborted_o        = r_aborted;
    assign fail_cnt_o       = r_fail;
    assign first_fail_vld_o = r_ff_vld;
    assign first_fail_idx_o = r_ff_idx;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the state-derived status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nxt = (num_pat_i == '0) ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_state_nxt = abort_i ? ST_DONE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    w_state_nxt = ST_DONE;
                end else if (w_settle_end) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = (abort_i || w_last) ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Settle timer: runs only while in SETTLE, otherwise parked at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
        end else if ((r_state == ST_SETTLE) && !abort_i && !w_settle_end) begin
            r_settle <= r_settle + 1'b1;
        end else begin
            r_settle <= '0;
        end
    end

    // Run bookkeeping: pattern, index, results; a capture is dropped on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num     <= '0;
            r_pat     <= '0;
            r_idx     <= '0;
            r_fail    <= '0;
            r_ff_vld  <= 1'b0;
            r_ff_idx  <= '0;
            r_aborted <= 1'b0;
        end else if (w_start_run) begin
            r_num     <= num_pat_i;
            r_pat     <= seed_i;
            r_idx     <= '0;
            r_fail    <= '0;
            r_ff_vld  <= 1'b0;
            r_ff_idx  <= '0;
            r_aborted <= 1'b0;
        end else begin
            if (w_abort) begin
                r_aborted <= 1'b1;
            end
            if (w_capture) begin
                if (w_mismatch) begin
                    if (r_fail != '1) begin
                        r_fail <= r_fail + 1'b1;
                    end
                    if (!r_ff_vld) begin
                        r_ff_vld <= 1'b1;
                        r_ff_idx <= r_idx;
                    end
                end
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                    r_pat <= r_pat + 1'b1;
                end
            end
        end
    end

`ifdef ATPG_MISR_EN
    logic [SIG_W-1:0] w_sig;

    atpg_misr #(
        .SIG_W (SIG_W)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (w_start_any),
        .shift (w_capture),
        .din   (resp_i),
        .sig   (w_sig)
    );

    assign signature_o = w_sig;
`endif

endmodule

// File: tb/tb_atpg_pattern_sequencer.sv
// Self-checking bench for atpg_pattern_sequencer: directed and random runs
// against a run-level reference model. Define ATPG_MISR_EN to cover the MISR.
module tb_atpg_pattern_sequencer;

    localparam int NUM_IN = 5;
    localparam int S      = 2;
    localparam int CNT_W  = 8;
    localparam int SIG_W  = 16;
    localparam int PER    = S + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic              abort_i;
    logic [NUM_IN-1:0] seed_i;
    logic [CNT_W-1:0]  num_pat_i;
    logic [NUM_IN-1:0] pat_o;
    logic              resp_i;
    logic              exp_i;
    logic              busy_o;
    logic              done_o;
    logic              aborted_o;
    logic [CNT_W-1:0]  fail_cnt_o;
    logic              first_fail_vld_o;
    logic [CNT_W-1:0]  first_fail_idx_o;
`ifdef ATPG_MISR_EN
    logic [SIG_W-1:0]  signature_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] bad_mask = '0;
    logic        resp_zero = 1'b0;

    // Reference results carried across runs.
    int          m_fail;
    logic        m_vld;
    int          m_idx;
    logic        m_abort;
    logic [15:0] m_sig;

    atpg_pattern_sequencer #(
        .NUM_IN     (NUM_IN),
        .SETTLE_CYC (S),
        .CNT_W      (CNT_W),
        .SIG_W      (SIG_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .seed_i           (seed_i),
        .num_pat_i        (num_pat_i),
        .pat_o            (pat_o),
        .resp_i           (resp_i),
        .exp_i            (exp_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .aborted_o        (aborted_o),
        .fail_cnt_o       (fail_cnt_o),
        .first_fail_vld_o (first_fail_vld_o),
        .first_fail_idx_o (first_fail_idx_o)
`ifdef ATPG_MISR_EN
        ,
        .signature_o      (signature_o)
`endif
    );

    always #5 clk = ~clk;

    // Golden CUT: pattern bits are {G0, G11, G12, G13, G14}.
    function automatic logic cut_fn(input logic [4:0] p);
        return (p[4] & p[3]) ^ (p[2] | ~p[1]) ^ p[0];
    endfunction

    // CUT instance stand-in; bad_mask marks patterns whose golden bit is flipped.
    always_comb begin
        resp_i = resp_zero ? 1'b0 : cut_fn(pat_o);
        exp_i  = cut_fn(pat_o) ^ bad_mask[pat_o];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_results(input string tag);
        chk({tag, ".fail_cnt"}, 32'(fail_cnt_o), 32'(m_fail));
        chk({tag, ".ff_vld"}, 32'(first_fail_vld_o), 32'(m_vld));
        chk({tag, ".ff_idx"}, 32'(first_fail_idx_o), 32'(m_idx));
        chk({tag, ".aborted"}, 32'(aborted_o), 32'(m_abort));
`ifdef ATPG_MISR_EN
        chk({tag, ".signature"}, 32'(signature_o), 32'(m_sig));
`endif
    endtask

    // One run: abort_cyc/restart_cyc = 0 means none; cycles counted from the start edge.
    task automatic run(input logic [4:0] seed, input int n, input logic [31:0] mask,
                       input int abort_cyc, input int restart_cyc);
        int          completed;
        int          done_cyc;
        logic [4:0]  p;
        logic        r;
        logic        e;
        logic [4:0]  pe;
        completed = (abort_cyc == 0) ? n : (((abort_cyc - 1) / PER < n) ? (abort_cyc - 1) / PER : n);
        done_cyc  = (n == 0) ? 1 : ((abort_cyc == 0) ? n * PER + 1 : abort_cyc + 1);
        m_sig = 16'hFFFF;
        if (n != 0) begin
            m_fail  = 0;
            m_vld   = 1'b0;
            m_idx   = 0;
            m_abort = (abort_cyc != 0);
        end
        for (int k = 0; k < completed; k++) begin
            p = 5'(seed + 5'(k));
            r = resp_zero ? 1'b0 : cut_fn(p);
            e = cut_fn(p) ^ mask[p];
            if (r != e) begin
                if (m_fail < 255) m_fail++;
                if (!m_vld) begin
                    m_vld = 1'b1;
                    m_idx = k;
                end
            end
            m_sig = {m_sig[14:0], 1'b0} ^ ((m_sig[15] ^ r) ? 16'h1021 : 16'h0000);
        end

        bad_mask = mask;
        @(negedge clk);
        seed_i    = seed;
        num_pat_i = CNT_W'(n);
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        seed_i    = 5'($urandom);
        num_pat_i = CNT_W'($urandom);
        for (int c = 1; c <= done_cyc; c++) begin
            start_i = (c == restart_cyc);
            abort_i = (c == abort_cyc);
            if (c < done_cyc) begin
                pe = 5'(seed + 5'((c - 1) / PER));
                chk("run.busy", 32'(busy_o), 32'd1);
                chk("run.done_early", 32'(done_o), 32'd0);
                chk("run.pat", 32'(pat_o), 32'(pe));
            end else begin
                chk("done.pulse", 32'(done_o), 32'd1);
                chk("done.busy", 32'(busy_o), 32'd1);
                check_results("done");
            end
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("idle.busy", 32'(busy_o), 32'd0);
        chk("idle.done", 32'(done_o), 32'd0);
        check_results("idle");
    endtask

    initial begin
        int          n;
        int          ab;
        int          rs;
        logic        saw_done;
        rst_n     = 1'b0;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        seed_i    = '0;
        num_pat_i = '0;
        m_fail    = 0;
        m_vld     = 1'b0;
        m_idx     = 0;
        m_abort   = 1'b0;
        m_sig     = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.pat", 32'(pat_o), 32'd0);
        check_results("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Empty run straight after reset.
        run(5'h00, 0, 32'h0, 0, 0);

        // Full sweep, all passing.
        run(5'h00, 32, 32'h0, 0, 0);
        chk("sweep.fail_cnt", 32'(fail_cnt_o), 32'd0);

        // Golden bit inverted at idx 5 and idx 9.
        run(5'h00, 32, 32'h0000_0220, 0, 0);
        chk("inv.fail_cnt", 32'(fail_cnt_o), 32'd2);
        chk("inv.ff_idx", 32'(first_fail_idx_o), 32'd5);

        // Wrap-around from 0x1E.
        run(5'h1E, 4, 32'h0, 0, 0);

        // Abort in the SETTLE of idx 3 of a 10-pattern run, extra start mid-run.
        run(5'h07, 10, 32'h0000_0400, 3 * PER + 2, 5);
        chk("abort.aborted", 32'(aborted_o), 32'd1);

`ifdef ATPG_MISR_EN
        resp_zero = 1'b1;
        run(5'h03, 4, 32'h0, 0, 0);
        chk("misr.sig_0e1f", 32'(signature_o), 32'h0000_0E1F);
        resp_zero = 1'b0;
`endif

        // Randomized runs.
        for (int t = 0; t < 25; t++) begin
            n  = $urandom_range(0, 40);
            ab = 0;
            rs = 0;
            if (n != 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, n * PER);
            if (n != 0 && $urandom_range(0, 1) == 0) rs = $urandom_range(1, n * PER);
            if (ab != 0 && rs > ab) rs = 0;
            resp_zero = ($urandom_range(0, 4) == 0);
            run(5'($urandom), n, $urandom & $urandom & $urandom, ab, rs);
        end
        resp_zero = 1'b0;

        // Reset asserted mid-run: outputs clear asynchronously, no done pulse.
        bad_mask = 32'hFFFF_FFFF;
        @(negedge clk);
        seed_i    = 5'h11;
        num_pat_i = 8'd10;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy_o), 32'd0);
        chk("arst.done", 32'(done_o), 32'd0);
        chk("arst.pat", 32'(pat_o), 32'd0);
        m_fail  = 0;
        m_vld   = 1'b0;
        m_idx   = 0;
        m_abort = 1'b0;
        m_sig   = '0;
        check_results("arst");
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (done_o || busy_o) saw_done = 1'b1;
        end
        chk("arst.no_done", 32'(saw_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
